// File: rtl/rob_drain_scheduler.sv
// rtl/rob_drain_scheduler.sv - in-order release sequencer for buffered R bursts.
// Optional protocol checker and sticky err port: define ROB_SCHED_CHK_EN.
module rob_drain_scheduler #(
    parameter int NUM_UIDS = 16,
    parameter int ID_WIDTH = 4,
    parameter int CNT_W    = $clog2(NUM_UIDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ID_WIDTH-1:0] issue_uid,
    output logic                issue_ready,
    input  logic                cmpl_valid,
    input  logic [ID_WIDTH-1:0] cmpl_uid,
    output logic                free_req,
    output logic [ID_WIDTH-1:0] uid_to_free,
    input  logic                free_ack,
    input  logic                pop_last,
    output logic [CNT_W-1:0]    outstanding,
`ifdef ROB_SCHED_CHK_EN
    output logic                busy,
    output logic                err
`else
    output logic                busy
`endif
);

    localparam int PTR_W = (NUM_UIDS > 1) ? $clog2(NUM_UIDS) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] q [NUM_UIDS];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W-1:0]    head_next;
    logic [PTR_W-1:0]    tail_next;
    logic [CNT_W-1:0]    count;
    logic [NUM_UIDS-1:0] done;
    logic [ID_WIDTH-1:0] head_uid;
    logic                issue_fire;
    logic                retire;

    assign head_uid    = q[head];
    assign issue_ready = (count != CNT_W'(NUM_UIDS));
    assign issue_fire  = issue_valid & issue_ready;
    assign retire      = (state == DRAIN) & free_ack & pop_last;
    assign head_next   = (head == PTR_W'(NUM_UIDS - 1)) ? '0 : head + PTR_W'(1);
    assign tail_next   = (tail == PTR_W'(NUM_UIDS - 1)) ? '0 : tail + PTR_W'(1);
    assign outstanding = count;
    assign busy        = (state == DRAIN);

    // Order queue, pointers, occupancy and completion bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UIDS; i++) begin
                q[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            if (issue_fire) begin
                q[tail] <= issue_uid;
                tail    <= tail_next;
            end
            if (retire) begin
                head <= head_next;
            end
            case ({issue_fire, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Completion set is applied last so it wins over a same-cycle clear.
            if (retire) begin
                done[head_uid] <= 1'b0;
            end
            if (issue_fire) begin
                done[issue_uid] <= 1'b0;
            end
            if (cmpl_valid) begin
                done[cmpl_uid] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            free_req    <= 1'b0;
            uid_to_free <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uid_to_free <= head_uid;
                    if ((count != '0) && done[head_uid]) begin
                        state    <= DRAIN;
                        free_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (free_ack && pop_last) begin
                        state    <= IDLE;
                        free_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    free_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROB_SCHED_CHK_EN
    logic [NUM_UIDS-1:0] pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            if (retire) begin
                pending[head_uid] <= 1'b0;
            end
            if (issue_fire) begin
                pending[issue_uid] <= 1'b1;
            end
            if ((issue_valid && !issue_ready) ||
                (cmpl_valid && (!pending[cmpl_uid] || done[cmpl_uid])) ||
                (free_ack && !free_req)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_drain_scheduler.sv
// tb/tb_rob_drain_scheduler.sv - directed self-checking bench for rob_drain_scheduler.
module tb_rob_drain_scheduler;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic [3:0] issue_uid;
    logic       issue_ready;
    logic       cmpl_valid;
    logic [3:0] cmpl_uid;
    logic       free_req;
    logic [3:0] uid_to_free;
    logic       free_ack;
    logic       pop_last;
    logic [4:0] outstanding;
    logic       busy;
`ifdef ROB_SCHED_CHK_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;

    rob_drain_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_uid   (issue_uid),
        .issue_ready (issue_ready),
        .cmpl_valid  (cmpl_valid),
        .cmpl_uid    (cmpl_uid),
        .free_req    (free_req),
        .uid_to_free (uid_to_free),
        .free_ack    (free_ack),
        .pop_last    (pop_last),
        .outstanding (outstanding),
`ifdef ROB_SCHED_CHK_EN
        .busy        (busy),
        .err         (err)
`else
        .busy        (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 0; issue_uid = 0; cmpl_valid = 0; cmpl_uid = 0;
        free_ack = 0; pop_last = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic issue_one(input logic [3:0] u);
        issue_valid = 1; issue_uid = u;
        tick();
        issue_valid = 0;
    endtask

    task automatic cmpl_one(input logic [3:0] u);
        cmpl_valid = 1; cmpl_uid = u;
        tick();
        cmpl_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_req !== 1'b0) begin errors++; $display("FAIL reset_free_req got %0b want 0", free_req); end
        checks++; if (uid_to_free !== 4'd0) begin errors++; $display("FAIL reset_uid got %0d want 0", uid_to_free); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    endtask

    task automatic test_single_burst();
        do_reset();
        issue_one(4'd3);
        checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL single_occ got %0d want 1", outstanding); end
        cmpl_one(4'd3);
        checks++; if (free_req !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", free_req); end
        tick();
        checks++; if (free_req !== 1'b1 || uid_to_free !== 4'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL single_start got req=%0b uid=%0d busy=%0b want 1/3/1", free_req, uid_to_free, busy); end
        for (int i = 0; i < 4; i++) begin
            free_ack = 1; pop_last = (i == 3);
            tick();
            if (i < 3) begin
                checks++; if (free_req !== 1'b1) begin errors++; $display("FAIL single_beat%0d got %0b want 1", i, free_req); end
            end
        end
        free_ack = 0; pop_last = 0;
        checks++; if (free_req !== 1'b0 || outstanding !== 5'd0) begin
            errors++; $display("FAIL single_end got req=%0b occ=%0d want 0/0", free_req, outstanding); end
    endtask

    task automatic test_out_of_order();
        logic [3:0] order [3];
        order[0] = 4'd1; order[1] = 4'd2; order[2] = 4'd5;
        do_reset();
        issue_one(4'd1); issue_one(4'd2); issue_one(4'd5);
        cmpl_one(4'd5);
        tick(); tick();
        checks++; if (free_req !== 1'b0) begin errors++; $display("FAIL ooo_wait got %0b want 0", free_req); end
        cmpl_one(4'd2);
        cmpl_one(4'd1);
        checks++; if (free_req !== 1'b0) begin errors++; $display("FAIL ooo_pre got %0b want 0", free_req); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (free_req !== 1'b1 || uid_to_free !== order[k]) begin
                errors++; $display("FAIL ooo_drain%0d got req=%0b uid=%0d want 1/%0d", k, free_req, uid_to_free, order[k]); end
            free_ack = 1; pop_last = 1;
            tick();
            free_ack = 0; pop_last = 0;
            checks++; if (free_req !== 1'b0) begin errors++; $display("FAIL ooo_gap%0d got %0b want 0", k, free_req); end
            tick();
        end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL ooo_occ got %0d want 0", outstanding); end
    endtask

    task automatic test_full_wrap();
        logic [3:0] exp_uid;
        do_reset();
        for (int i = 0; i < 16; i++) issue_one(4'(i));
        checks++; if (issue_ready !== 1'b0 || outstanding !== 5'd16) begin
            errors++; $display("FAIL full got ready=%0b occ=%0d want 0/16", issue_ready, outstanding); end
        issue_valid = 1; issue_uid = 4'd0;
        cmpl_one(4'd0);
        issue_valid = 1;
        tick();
        checks++; if (free_req !== 1'b1 || uid_to_free !== 4'd0 || outstanding !== 5'd16) begin
            errors++; $display("FAIL full_drain got req=%0b uid=%0d occ=%0d want 1/0/16", free_req, uid_to_free, outstanding); end
        free_ack = 1; pop_last = 1;
        tick();
        free_ack = 0; pop_last = 0;
        checks++; if (outstanding !== 5'd15 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL full_retire got occ=%0d ready=%0b want 15/1", outstanding, issue_ready); end
        tick();
        issue_valid = 0;
        checks++; if (outstanding !== 5'd16 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL full_refill got occ=%0d ready=%0b want 16/0", outstanding, issue_ready); end
        for (int i = 1; i < 16; i++) cmpl_one(4'(i));
        cmpl_one(4'd0);
        for (int k = 0; k < 16; k++) begin
            exp_uid = 4'(k + 1);
            for (int w = 0; w < 8 && free_req !== 1'b1; w++) tick();
            checks++; if (free_req !== 1'b1 || uid_to_free !== exp_uid) begin
                errors++; $display("FAIL wrap_drain%0d got req=%0b uid=%0d want 1/%0d", k, free_req, uid_to_free, exp_uid); end
            free_ack = 1; pop_last = 1;
            tick();
            free_ack = 0; pop_last = 0;
        end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL wrap_occ got %0d want 0", outstanding); end
    endtask

    task automatic test_stall();
        do_reset();
        issue_one(4'd9);
        cmpl_one(4'd9);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (free_req !== 1'b1 || uid_to_free !== 4'd9 || outstanding !== 5'd1) begin
                errors++; $display("FAIL stall%0d got req=%0b uid=%0d occ=%0d want 1/9/1", i, free_req, uid_to_free, outstanding); end
        end
        free_ack = 1; pop_last = 0;
        tick();
        checks++; if (free_req !== 1'b1) begin errors++; $display("FAIL stall_mid got %0b want 1", free_req); end
        pop_last = 1;
        tick();
        free_ack = 0; pop_last = 0;
        checks++; if (free_req !== 1'b0 || outstanding !== 5'd0) begin
            errors++; $display("FAIL stall_end got req=%0b occ=%0d want 0/0", free_req, outstanding); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        issue_one(4'd4);
        cmpl_one(4'd4);
        tick();
        checks++; if (free_req !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", free_req); end
        #2 rst_n = 0;
        #1;
        checks++; if (free_req !== 1'b0 || outstanding !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_async got req=%0b occ=%0d busy=%0b want 0/0/0", free_req, outstanding, busy); end
        tick();
        rst_n = 1;
        tick();
        checks++; if (issue_ready !== 1'b1 || free_req !== 1'b0) begin
            errors++; $display("FAIL mid_after got ready=%0b req=%0b want 1/0", issue_ready, free_req); end
    endtask

`ifdef ROB_SCHED_CHK_EN
    task automatic test_err();
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset got %0b want 0", err); end
        cmpl_one(4'd7);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
        tick(); tick(); tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_out_of_order();
        test_full_wrap();
        test_stall();
        test_reset_mid_drain();
`ifdef ROB_SCHED_CHK_EN
        test_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
